// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
// Supports up to MAX_REQ requesters; the search is done on a zero-extended request vector.
package fifo_arb_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic bit idx_width_ok(input int num_req, input int idx_width);
        return (num_req >= 2) && (num_req <= MAX_REQ) && (idx_width <= MAX_IDX_W)
               && (num_req <= (1 << idx_width));
    endfunction

    // Scans base+1, base+2, ... modulo num_req; the optional exclude index is skipped.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int num_req,
                                         input int base, input logic excl_en, input int excl);
        rr_pick_t r;
        int       idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req) begin
                idx = (base + k) % num_req;
                if (!r.found && req[idx[MAX_IDX_W-1:0]] && !(excl_en && (idx == excl))) begin
                    r.found = 1'b1;
                    r.idx   = idx[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Combinational round-robin picker: searches from base+1 and can exclude base itself,
// which covers both the idle arbitration and the owner-handover search.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] base,
    input  logic                 excl_en,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] winner
);

    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;
    logic               pick_unused;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick = rr_pick(req_ext, NUM_REQ, int'(base), excl_en, int'(base));
    end

    assign found       = pick.found;
    assign winner      = pick.idx[IDX_WIDTH-1:0];
    assign pick_unused = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_BURST_LOCK_EN to hold ownership until req_last; otherwise every word ends ownership.
//
// state | meaning
// IDLE  | no owner; pick a winner from rr_last+1, no FIFO write this cycle
// OWN   | owner's words go to the FIFO; handover on the ending word with zero bubble
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            clear_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              gnt,
    input  logic                            fifo_full,
    output logic                            fifo_wr,
    output logic [DATA_WIDTH-1:0]           fifo_data_in,
    output logic                            busy,
    output logic [IDX_WIDTH-1:0]            owner
);

    localparam bit CFG_OK = idx_width_ok(NUM_REQ, IDX_WIDTH);
    generate
        if (!CFG_OK) begin : g_cfg_bad
            $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and fit in IDX_WIDTH bits");
        end
    endgenerate

    arb_state_t           state, state_nx;
    logic [IDX_WIDTH-1:0] owner_nx, rr_last, rr_last_nx;
    logic [IDX_WIDTH-1:0] sel_base, sel_winner;
    logic                 sel_found, burst_end;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // In OWN the search starts after the owner and skips it, so a sole requester falls to IDLE.
    assign sel_base = (state == OWN) ? owner : rr_last;

    rr_select #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_select (
        .req     (req),
        .base    (sel_base),
        .excl_en (state == OWN),
        .found   (sel_found),
        .winner  (sel_winner)
    );

    assign busy = (state == OWN);

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    assign burst_end = fifo_wr && req_last[owner];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign burst_end   = fifo_wr;
`endif

    always_comb begin
        fifo_wr      = 1'b0;
        fifo_data_in = '0;
        gnt          = '0;
        if (state == OWN) begin
            fifo_wr      = req[owner] && !fifo_full;
            fifo_data_in = words[owner];
            if (fifo_wr) begin
                gnt[owner] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        rr_last_nx = rr_last;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nx = OWN;
                    owner_nx = sel_winner;
                end
            end
            OWN: begin
                if (burst_end) begin
                    rr_last_nx = owner;
                    if (sel_found) begin
                        owner_nx = sel_winner;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            owner   <= '0;
            rr_last <= IDX_WIDTH'(NUM_REQ - 1);
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            rr_last <= rr_last_nx;
        end
    end

endmodule
